// File: rtl/obstacle_collision_if.sv
// Geometry inputs and collision status outputs exchanged between the game logic and obstacle_collision.
interface obstacle_collision_if;
  logic [9:0] BeeX;
  logic [9:0] BeeY;
  logic [9:0] BeeS;
  logic [9:0] ObsX;
  logic [9:0] ObsY;
  logic [9:0] ObsWidth;
  logic [9:0] ObsHeight;
  logic       start;
  logic       overlap;
  logic       hit;
  logic [1:0] lives;
  logic       invuln;
  logic       game_over;
  logic       bee_visible;

  modport master (
    output BeeX, BeeY, BeeS, ObsX, ObsY, ObsWidth, ObsHeight, start,
    input  overlap, hit, lives, invuln, game_over, bee_visible
  );

  modport slave (
    input  BeeX, BeeY, BeeS, ObsX, ObsY, ObsWidth, ObsHeight, start,
    output overlap, hit, lives, invuln, game_over, bee_visible
  );
endinterface

// File: rtl/obstacle_collision.sv
// Bee/obstacle box collision, lives, post-hit invulnerability window and game-over control.
// Optional macro COLLISION_BLINK_EN: blink the bee (bee_visible) while invulnerable.
module obstacle_collision #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_SHIFT   = 2
) (
  input logic                 frame_clk,
  input logic                 Reset,
  obstacle_collision_if.slave bus
);

  localparam int unsigned CW = 11;
  localparam int unsigned IW = 8;

  typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} state_t;

  // Reject out-of-range parameters at elaboration time.
  if (LIVES_INIT < 1 || LIVES_INIT > 3 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255 || BLINK_SHIFT > 7)
  begin : g_param_check
    $error("obstacle_collision: parameter out of range");
  end

  // Stage 1: absolute centre distance against combined half-extents.
  logic signed [CW-1:0] diff_x, diff_y;
  logic [CW-1:0]        dx, dy, reach_x, reach_y;
  logic                 overlap_d;

  always_comb begin
    diff_x    = $signed({1'b0, bus.BeeX}) - $signed({1'b0, bus.ObsX});
    diff_y    = $signed({1'b0, bus.BeeY}) - $signed({1'b0, bus.ObsY});
    dx        = diff_x[CW-1] ? CW'(-diff_x) : CW'(diff_x);
    dy        = diff_y[CW-1] ? CW'(-diff_y) : CW'(diff_y);
    reach_x   = CW'(bus.BeeS) + CW'(bus.ObsWidth >> 1);
    reach_y   = CW'(bus.BeeS) + CW'(bus.ObsHeight >> 1);
    overlap_d = (dx < reach_x) && (dy < reach_y);
  end

  state_t          state_q, state_d;
  logic [1:0]      lives_q, lives_d;
  logic [IW-1:0]   inv_cnt_q, inv_cnt_d;
  logic            overlap_q;
  logic            hit_q, hit_d;
  logic            invuln_q, game_over_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= PLAY;
      lives_q     <= 2'(LIVES_INIT);
      inv_cnt_q   <= '0;
      overlap_q   <= 1'b0;
      hit_q       <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      overlap_q   <= overlap_d;
      hit_q       <= hit_d;
      invuln_q    <= (state_d == INVULN);
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  // Stage 2: acts on the registered overlap, so a hit lags contact by one frame.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    hit_d     = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (overlap_q) begin
          hit_d = 1'b1;
          if (lives_q > 2'd1) begin
            lives_d   = lives_q - 2'd1;
            inv_cnt_d = IW'(INVULN_FRAMES - 1);
            state_d   = INVULN;
          end else begin
            lives_d = 2'd0;
            state_d = GAME_OVER;
          end
        end
      end
      INVULN: begin
        if (inv_cnt_q == '0) begin
          state_d = PLAY;
        end else begin
          inv_cnt_d = inv_cnt_q - IW'(1);
        end
      end
      GAME_OVER: begin
        lives_d = 2'd0;
        if (bus.start) begin
          lives_d = 2'(LIVES_INIT);
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  assign bus.overlap   = overlap_q;
  assign bus.hit       = hit_q;
  assign bus.lives     = lives_q;
  assign bus.invuln    = invuln_q;
  assign bus.game_over = game_over_q;

`ifdef COLLISION_BLINK_EN
  localparam int unsigned BW = BLINK_SHIFT + 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          bee_visible_q, bee_visible_d;

  // Free-running blink counter, restarted on entry into INVULN.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BW'(1);
    bee_visible_d = 1'b1;
    if (state_d == INVULN && state_q != INVULN) begin
      blink_cnt_d = '0;
    end
    if (state_d == INVULN) begin
      bee_visible_d = ~blink_cnt_d[BLINK_SHIFT];
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt_q   <= '0;
      bee_visible_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      bee_visible_q <= bee_visible_d;
    end
  end

  assign bus.bee_visible = bee_visible_q;
`else
  assign bus.bee_visible = 1'b1;
`endif

endmodule
